// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: types and constants shared by the shift-add multiplier
// sequencer and its ALU port mux.
//   csr_t        : ALU / product flag bundle (Sign, Zero, Carry, Overflow)
//   mul_state_t  : sequencer FSM states (NEG_LO/NEG_HI only with MUL_SIGNED_EN)
//   ALU_*        : shared-ALU opcodes driven by the sequencer
//   MUL_ITER     : number of shift-add iterations
// Configuration macro: MUL_SIGNED_EN (signed operand support).
package mul_sequencer_pkg;

   typedef struct packed {
      logic Sign;
      logic Zero;
      logic Carry;
      logic Overflow;
   } csr_t;

`ifdef MUL_SIGNED_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RUN    = 3'd1,
      NEG_LO = 3'd2,
      NEG_HI = 3'd3,
      DONE   = 3'd4
   } mul_state_t;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN  = 3'd1,
      DONE = 3'd4
   } mul_state_t;
`endif

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_NOT = 3'b101;

   localparam int MUL_ITER = 16;

   // Two's-complement magnitude; 0x8000 maps to 0x8000, which is correct
   // when the result is treated as unsigned.
   function automatic logic [15:0] abs16(input logic [15:0] x);
      return x[15] ? (~x + 16'd1) : x;
   endfunction

   // Flags of a finished product. Carry and Overflow both mean "the upper
   // half carries information beyond the lower half".
   function automatic csr_t product_csr(input logic [15:0] hi,
                                        input logic [15:0] lo,
                                        input logic        sgn);
      csr_t f;
      logic ovf;
      ovf        = sgn ? (hi != {16{lo[15]}}) : (hi != 16'd0);
      f.Sign     = hi[15];
      f.Zero     = ({hi, lo} == 32'd0);
      f.Carry    = ovf;
      f.Overflow = ovf;
      return f;
   endfunction

endpackage

// File: rtl/mul_sequencer_alu_port_mux.sv
// alu_port_mux: 2:1 select of the shared ALU input ports.
//   busy               : 1 = sequencer owns the ALU, 0 = pipeline owns it
//   pipe_ctrl/src1/src2: pipeline-side opcode and operands
//   seq_ctrl/src1/src2 : sequencer-side opcode and operands
//   alu_ctrl/src1/src2 : to the shared ALU
module alu_port_mux #(
   parameter int DATA_W = 16
) (
   input  logic              busy,
   input  logic [2:0]        pipe_ctrl,
   input  logic [DATA_W-1:0] pipe_src1,
   input  logic [DATA_W-1:0] pipe_src2,
   input  logic [2:0]        seq_ctrl,
   input  logic [DATA_W-1:0] seq_src1,
   input  logic [DATA_W-1:0] seq_src2,
   output logic [2:0]        alu_ctrl,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2
);

   always_comb begin
      if (busy) begin
         alu_ctrl = seq_ctrl;
         alu_src1 = seq_src1;
         alu_src2 = seq_src2;
      end else begin
         alu_ctrl = pipe_ctrl;
         alu_src1 = pipe_src1;
         alu_src2 = pipe_src2;
      end
   end

endmodule

// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle 16x16->32 shift-add multiplier that borrows the
// core's shared combinational ALU (no adder of its own in the datapath).
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/ready/a/b/signed : multiply request handshake and operands
//   resp_valid/ready/hi/lo/csr : product handshake, product halves, flags
//   pipe_alu_req/ctrl/src1/src2: pipeline's ALU request, passed through when idle
//   pipe_stall                 : pipeline must stall (it wants the ALU, we own it)
//   alu_ctrl/src1/src2         : to shared ALU
//   alu_ret, alu_csr           : from shared ALU (only Carry is used)
// Configuration macro: MUL_SIGNED_EN (honour req_signed; adds NEG_LO/NEG_HI).
module mul_sequencer
   import mul_sequencer_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   input  logic              req_signed,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_hi,
   output logic [DATA_W-1:0] resp_lo,
   output csr_t              resp_csr,
   input  logic              pipe_alu_req,
   input  logic [2:0]        pipe_alu_ctrl,
   input  logic [DATA_W-1:0] pipe_src1,
   input  logic [DATA_W-1:0] pipe_src2,
   output logic              pipe_stall,
   output logic [2:0]        alu_ctrl,
   output logic [DATA_W-1:0] alu_src1,
   output logic [DATA_W-1:0] alu_src2,
   input  logic [DATA_W-1:0] alu_ret,
   input  csr_t              alu_csr
);

   localparam int CNT_W = $clog2(DATA_W);

   if (DATA_W != 16) begin : g_width_check
      $error("mul_sequencer: DATA_W must be 16 (shared ALU is 16-bit)");
   end

   mul_state_t        state;
   logic [DATA_W-1:0] mcand;
   logic [DATA_W-1:0] hi;
   logic [DATA_W-1:0] lo;
   logic [CNT_W-1:0]  cnt;
   logic              busy;
   logic              sgn_op;
   logic [2:0]        seq_ctrl;
   logic [DATA_W-1:0] seq_src1;
   logic [DATA_W-1:0] seq_src2;

   logic [2:0] unused_alu_flags;
   assign unused_alu_flags = {alu_csr.Sign, alu_csr.Zero, alu_csr.Overflow};

`ifdef MUL_SIGNED_EN
   logic neg;
   logic borrow;
`else
   logic unused_req_signed;
   assign unused_req_signed = req_signed;
   assign sgn_op = 1'b0;
`endif

   assign busy       = (state != IDLE) && (state != DONE);
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == DONE);
   assign pipe_stall = pipe_alu_req & busy;
   assign resp_hi    = hi;
   assign resp_lo    = lo;
   assign resp_csr   = (state == DONE) ? product_csr(hi, lo, sgn_op) : '0;

   always_comb begin
      seq_ctrl = ALU_ADD;
      seq_src1 = '0;
      seq_src2 = '0;
      case (state)
         RUN: begin
            seq_ctrl = ALU_ADD;
            seq_src1 = hi;
            seq_src2 = lo[0] ? mcand : '0;
         end
`ifdef MUL_SIGNED_EN
         // Negate {hi,lo}: lo = -lo; hi = -hi if lo was zero, else ~hi.
         NEG_LO: begin
            seq_ctrl = ALU_SUB;
            seq_src2 = lo;
         end
         NEG_HI: begin
            seq_ctrl = borrow ? ALU_SUB : ALU_NOT;
            seq_src2 = hi;
         end
`endif
         default: ;
      endcase
   end

   alu_port_mux #(
      .DATA_W (DATA_W)
   ) u_alu_port_mux (
      .busy      (busy),
      .pipe_ctrl (pipe_alu_ctrl),
      .pipe_src1 (pipe_src1),
      .pipe_src2 (pipe_src2),
      .seq_ctrl  (seq_ctrl),
      .seq_src1  (seq_src1),
      .seq_src2  (seq_src2),
      .alu_ctrl  (alu_ctrl),
      .alu_src1  (alu_src1),
      .alu_src2  (alu_src2)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         mcand  <= '0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
`ifdef MUL_SIGNED_EN
         neg    <= 1'b0;
         borrow <= 1'b0;
         sgn_op <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  state <= RUN;
                  hi    <= '0;
                  cnt   <= '0;
`ifdef MUL_SIGNED_EN
                  if (req_signed) begin
                     mcand  <= abs16(req_a);
                     lo     <= abs16(req_b);
                     neg    <= req_a[DATA_W-1] ^ req_b[DATA_W-1];
                     sgn_op <= 1'b1;
                  end else begin
                     mcand  <= req_a;
                     lo     <= req_b;
                     neg    <= 1'b0;
                     sgn_op <= 1'b0;
                  end
`else
                  mcand <= req_a;
                  lo    <= req_b;
`endif
               end
            end
            RUN: begin
               // ALU carry-out becomes the new MSB so 0xFFFF*0xFFFF keeps it.
               {hi, lo} <= {alu_csr.Carry, alu_ret, lo[DATA_W-1:1]};
               cnt      <= cnt + 1'b1;
               if (cnt == CNT_W'(MUL_ITER - 1)) begin
`ifdef MUL_SIGNED_EN
                  state <= neg ? NEG_LO : DONE;
`else
                  state <= DONE;
`endif
               end
            end
`ifdef MUL_SIGNED_EN
            NEG_LO: begin
               lo     <= alu_ret;
               borrow <= alu_csr.Carry;
               state  <= NEG_HI;
            end
            NEG_HI: begin
               hi    <= alu_ret;
               state <= DONE;
            end
`endif
            DONE: begin
               if (resp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed self-checking bench for mul_sequencer, with a
// behavioural model of the shared ALU (ADD, SUB with carry = no-borrow, NOT).
// Configuration macro: MUL_SIGNED_EN selects the signed-mode vectors.
module tb_mul_sequencer;
   import mul_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic        req_signed;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_hi;
   logic [15:0] resp_lo;
   csr_t        resp_csr;
   logic        pipe_alu_req;
   logic [2:0]  pipe_alu_ctrl;
   logic [15:0] pipe_src1;
   logic [15:0] pipe_src2;
   logic        pipe_stall;
   logic [2:0]  alu_ctrl;
   logic [15:0] alu_src1;
   logic [15:0] alu_src2;
   logic [15:0] alu_ret;
   csr_t        alu_csr;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mul_sequencer #(
      .DATA_W (16)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_signed    (req_signed),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready),
      .resp_hi       (resp_hi),
      .resp_lo       (resp_lo),
      .resp_csr      (resp_csr),
      .pipe_alu_req  (pipe_alu_req),
      .pipe_alu_ctrl (pipe_alu_ctrl),
      .pipe_src1     (pipe_src1),
      .pipe_src2     (pipe_src2),
      .pipe_stall    (pipe_stall),
      .alu_ctrl      (alu_ctrl),
      .alu_src1      (alu_src1),
      .alu_src2      (alu_src2),
      .alu_ret       (alu_ret),
      .alu_csr       (alu_csr)
   );

   // Shared ALU model
   always_comb begin
      logic [16:0] sum;
      sum = 17'd0;
      case (alu_ctrl)
         3'b000:  sum = {1'b0, alu_src1} + {1'b0, alu_src2};
         3'b001:  sum = {1'b0, alu_src1} + {1'b0, ~alu_src2} + 17'd1;
         3'b101:  sum = {1'b0, ~alu_src2};
         default: sum = {1'b0, alu_src1 & alu_src2};
      endcase
      alu_ret          = sum[15:0];
      alu_csr.Carry    = sum[16];
      alu_csr.Sign     = sum[15];
      alu_csr.Zero     = (sum[15:0] == 16'd0);
      alu_csr.Overflow = 1'b0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_mul(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic pipe, input logic poke, input int hold,
                         input logic [31:0] exp_p, input int exp_lat,
                         input logic exp_c, input logic exp_z, input logic exp_s);
      int lat;
      int stalls;
      resp_ready = (hold == 0);
      @(negedge clk);
      req_a = a; req_b = b; req_signed = s; req_valid = 1'b1; pipe_alu_req = pipe;
      chk("accept_ready", 32'(req_ready), 32'd1);
      chk("accept_stall", 32'(pipe_stall), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      stalls = 0;
      while (resp_valid !== 1'b1 && lat < 60) begin
         if (pipe_stall === 1'b1) stalls++;
         if (lat == 3) chk("run_alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
         if (poke && lat == 5) begin
            req_a = 16'h5555; req_b = 16'h0003; req_valid = 1'b1;
            chk("run_not_ready", 32'(req_ready), 32'd0);
         end
         if (poke && lat == 6) req_valid = 1'b0;
         @(negedge clk);
         lat++;
      end
      req_valid = 1'b0;
      chk("latency", 32'(lat), 32'(exp_lat));
      chk("stall_cycles", 32'(stalls), pipe ? 32'(exp_lat - 1) : 32'd0);
      chk("done_stall", 32'(pipe_stall), 32'd0);
      chk("product", {resp_hi, resp_lo}, exp_p);
      chk("csr_carry", 32'(resp_csr.Carry), 32'(exp_c));
      chk("csr_ovf", 32'(resp_csr.Overflow), 32'(exp_c));
      chk("csr_zero", 32'(resp_csr.Zero), 32'(exp_z));
      chk("csr_sign", 32'(resp_csr.Sign), 32'(exp_s));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_product", {resp_hi, resp_lo}, exp_p);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("back_idle_ready", 32'(req_ready), 32'd1);
      chk("back_idle_valid", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      int seen;
      rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_signed = 1'b0;
      resp_ready = 1'b1; pipe_alu_req = 1'b0; pipe_alu_ctrl = 3'b010;
      pipe_src1 = 16'h00F0; pipe_src2 = 16'h0FF0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp", {resp_hi, resp_lo}, 32'd0);
      chk("rst_csr", 32'(resp_csr), 32'd0);
      chk("rst_stall", 32'(pipe_stall), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_alu_ctrl", 32'(alu_ctrl), 32'h2);
      chk("idle_alu_src1", 32'(alu_src1), 32'h00F0);
      chk("idle_alu_src2", 32'(alu_src2), 32'h0FF0);

      do_mul(16'd3, 16'd5, 1'b0, 1'b0, 1'b0, 0, 32'h0000000F, 17, 1'b0, 1'b0, 1'b0);
      do_mul(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, 32'hFFFE0001, 17, 1'b1, 1'b0, 1'b1);
      do_mul(16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 32'h00000000, 17, 1'b0, 1'b1, 1'b0);
      do_mul(16'h0100, 16'h0100, 1'b0, 1'b1, 1'b0, 0, 32'h00010000, 17, 1'b1, 1'b0, 1'b0);
      pipe_alu_req = 1'b0;

      // Reset in RUN cycle 8 abandons the operation
      @(negedge clk);
      req_a = 16'h00AA; req_b = 16'h0003; req_signed = 1'b0; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst_ready", 32'(req_ready), 32'd1);
      chk("midrst_valid", 32'(resp_valid), 32'd0);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) seen++;
      end
      chk("midrst_no_resp", 32'(seen), 32'd0);
      do_mul(16'd7, 16'd6, 1'b0, 1'b0, 1'b0, 0, 32'h0000002A, 17, 1'b0, 1'b0, 1'b0);

`ifdef MUL_SIGNED_EN
      do_mul(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 0, 32'hFFFFFFFF, 19, 1'b0, 1'b0, 1'b1);
      do_mul(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, 0, 32'h40000000, 17, 1'b1, 1'b0, 1'b0);
      do_mul(16'hFF00, 16'h0100, 1'b1, 1'b1, 1'b0, 0, 32'hFFFF0000, 19, 1'b1, 1'b0, 1'b1);
      do_mul(16'hFFFD, 16'h0005, 1'b1, 1'b0, 1'b0, 5, 32'hFFFFFFF1, 19, 1'b0, 1'b0, 1'b1);
      do_mul(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 32'h0000FFFF, 17, 1'b0, 1'b0, 1'b0);
`else
      do_mul(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 0, 32'h0000FFFF, 17, 1'b0, 1'b0, 1'b0);
      do_mul(16'h0011, 16'h0003, 1'b0, 1'b0, 1'b0, 5, 32'h00000033, 17, 1'b0, 1'b0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle 16x16 -> 32-bit multiplier that performs shift-add by borrowing the core's shared combinational ALU; it holds no adder of its own.
- Sits beside the execute stage and muxes the ALU input ports between the pipeline and itself.
- Stalls the pipeline while it owns the ALU.

Parameters:
DATA_W, 16, operand width; only 16 is legal (ALU is fixed 16-bit); elaboration error otherwise.
CNT_W, $clog2(DATA_W), iteration counter width (derived, not overridden).

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  multiply request
req_ready  output  1  high only in IDLE
req_a  input  16  multiplicand
req_b  input  16  multiplier
req_signed  input  1  signed operands (ignored unless MUL_SIGNED_EN)
resp_valid  output  1  result available
resp_ready  input  1  consumer accepts result
resp_hi  output  16  product[31:16]
resp_lo  output  16  product[15:0]
resp_csr  output  csr_t  flags of product
pipe_alu_req  input  1  pipeline wants the ALU this cycle
pipe_alu_ctrl  input  3  pipeline ALU opcode
pipe_src1  input  16  pipeline operand 1
pipe_src2  input  16  pipeline operand 2
pipe_stall  output  1  pipe_alu_req & busy
alu_ctrl  output  3  to shared ALU
alu_src1  output  16  to shared ALU
alu_src2  output  16  to shared ALU
alu_ret  input  16  ALU result
alu_csr  input  csr_t  ALU flags (Carry used)

Behaviour:
- Reset: all state is synchronous on rst_n low and returns the block to IDLE. Outputs after reset: req_ready=1, resp_valid=0, resp_hi/lo=0, resp_csr=0, pipe_stall=0. Reset mid-operation abandons the operation; no response is produced.
- States: IDLE, RUN, NEG_LO, NEG_HI, DONE. busy = state not in {IDLE, DONE}.
- IDLE -> RUN on req_valid & req_ready.
  - Latch mcand=req_a, lo=req_b, hi=0, cnt=0.
  - Signed mode: latch |a|, |b| and neg = a[15]^b[15].
- RUN, one iteration per cycle, 16 cycles:
  - Drive alu_ctrl=000 (ADD), alu_src1=hi, alu_src2 = lo[0] ? mcand : 0.
  - Update {hi,lo} <= {alu_csr.Carry, alu_ret, lo[15:1]}.
  - At cnt==15: go to NEG_LO if neg, else DONE.
- NEG_LO (signed only):
  - Drive ALU SUB (001), src1=0, src2=lo; lo <= alu_ret.
  - Save borrow = alu_csr.Carry, which is 1 iff lo was 0.
- NEG_HI (signed only):
  - If borrow: drive SUB, src1=0, src2=hi. Else: drive NOT (101), src2=hi.
  - hi <= alu_ret; go to DONE.
- DONE:
  - resp_valid=1; resp_hi/lo/csr stable.
  - Leave to IDLE on resp_ready; hold indefinitely otherwise.
  - Sign = product[31]; Zero = (product==0).
  - Carry = Overflow = upper half significant: unsigned: hi!=0; signed: hi != {16{lo[15]}}.
- Latency, acceptance to resp_valid: unsigned 17 cycles; signed 19 cycles.
- ALU mux: when busy, the sequencer drives the ALU and the pipe_* inputs are ignored. In IDLE and DONE the ALU is driven from pipe_* unchanged, combinationally.
- pipe_stall is combinational. A pipeline request in the acceptance cycle wins the ALU in that cycle; the stall starts the next cycle.
- req_valid while not ready is ignored; requesters hold req_* until accepted.
- 0xFFFF*0xFFFF unsigned must not lose the carry (hi 0xFFFE).

Optional Feature:
MUL_SIGNED_EN:
- Defined: req_signed honoured; abs-value inputs; NEG_LO/NEG_HI states present.
- Undefined: req_signed ignored; all operations are unsigned; NEG states absent; latency is always 17.

Decomposition:
- Add to the shared types package:
  - mul_state_t enum.
  - ALU opcode constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_NOT=3'b101, replacing literals.
  - MUL_ITER=16.
- One natural sub-module, alu_port_mux: a 2:1 select of {ctrl,src1,src2} on busy, reusable by future ALU clients.
- The ALU itself is instantiated outside, at core level.

Test Plan:
- Unsigned 3*5 -> resp_valid 17 cycles after acceptance; hi=0x0000, lo=0x000F, Zero=0, Carry=0.
- Unsigned 0xFFFF*0xFFFF -> hi=0xFFFE, lo=0x0001, Carry=1, Sign=1.
- Multiply by 0 (0x1234*0) -> product 0, Zero=1. A second req_valid during RUN is not accepted (req_ready=0).
- Pipeline sharing: pipe_alu_req=1 throughout the multiply:
  - pipe_stall=1 for exactly the 16 RUN cycles.
  - In IDLE, alu_* equals pipe_* (e.g. ctrl=010, src1=0x00F0, src2=0x0FF0).
- rst_n low in RUN cycle 8 -> next cycle IDLE, req_ready=1, resp_valid never asserted. A fresh 7*6 then yields 0x0000002A.
- MUL_SIGNED_EN, back-pressure checks:
  - -1*1 -> 0xFFFFFFFF, Sign=1, Carry=0, latency 19.
  - -32768*-32768 -> 0x40000000, Carry=1.
  - resp_ready held low 5 cycles -> outputs stable, then IDLE.
